// File: rtl/rca_pipe_pkg.sv
// Shared defaults and the single-bit full-add primitive used by the segment
// ripple chains.
package rca_pipe_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SEG   = 8;

  // Returns {carry, sum} of a one-bit full add.
  function automatic logic [1:0] fa_bits(input logic x, input logic y, input logic c);
    return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
  endfunction

endpackage

// File: rtl/rca_pipe_if.sv
// Streaming operand/result bus of the pipelined adder: valid/ready on both sides.
interface rca_pipe_if #(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, s, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, s, c_out, ovf
  );

endinterface

// File: rtl/rca_seg.sv
// One SEG-bit ripple segment built from full_adder cells; also exposes the
// carry into its top cell so the last segment can flag signed overflow.
module full_adder
  import rca_pipe_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  assign {c_out, s} = fa_bits(a, b, c_in);

endmodule

module rca_seg #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           c_in,
  output logic [SEG-1:0] s,
  output logic           c_out,
  output logic           c_msb
);

  logic [SEG:0] c;

  assign c[0] = c_in;

  for (genvar j = 0; j < SEG; j++) begin : g_fa
    full_adder u_fa (
      .a     (a[j]),
      .b     (b[j]),
      .c_in  (c[j]),
      .s     (s[j]),
      .c_out (c[j+1])
    );
  end

  assign c_out = c[SEG];
  assign c_msb = c[SEG-1];

endmodule

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder/subtractor: one SEG-bit segment per stage,
// operands skewed forward with the beat, valid/ready back-pressure per stage.
module rca_pipe
  import rca_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input logic       clk,
  input logic       rst_n,
  rca_pipe_if.slave bus
);

  localparam int NSTG = WIDTH / SEG;

  logic [NSTG-1:0]  vld_p;
  logic [NSTG-1:0]  cy_p;
  logic [WIDTH-1:0] sum_p [NSTG];
  logic [WIDTH-1:0] a_p   [NSTG];
  logic [WIDTH-1:0] b_p   [NSTG];
  logic             ovf_p;

  logic [NSTG:0]    rdy;
  logic [SEG-1:0]   seg_a [NSTG];
  logic [SEG-1:0]   seg_b [NSTG];
  logic [SEG-1:0]   seg_s [NSTG];
  logic [NSTG-1:0]  seg_ci;
  logic [NSTG-1:0]  seg_co;
  logic [NSTG-1:0]  seg_cm;
  logic [WIDTH-1:0] b_in;
  logic             unused_skew;

  // Subtraction is a + ~b + 1; only the inverted B travels down the pipe.
  assign b_in = bus.sub ? ~bus.b : bus.b;

  always_comb begin
    logic r;
    r         = bus.out_ready;
    rdy       = '0;
    rdy[NSTG] = r;
    for (int i = NSTG - 1; i >= 0; i--) begin
      r      = !vld_p[i] || r;
      rdy[i] = r;
    end
  end

  // Skew registers are shifted down each stage so the next segment is always
  // in the low SEG bits.
  always_comb begin
    seg_a[0]  = bus.a[SEG-1:0];
    seg_b[0]  = b_in[SEG-1:0];
    seg_ci    = '0;
    seg_ci[0] = bus.sub | bus.c_in;
    for (int i = 1; i < NSTG; i++) begin
      seg_a[i]  = a_p[i-1][SEG-1:0];
      seg_b[i]  = b_p[i-1][SEG-1:0];
      seg_ci[i] = cy_p[i-1];
    end
  end

  for (genvar g = 0; g < NSTG; g++) begin : g_seg
    rca_seg #(.SEG(SEG)) u_seg (
      .a     (seg_a[g]),
      .b     (seg_b[g]),
      .c_in  (seg_ci[g]),
      .s     (seg_s[g]),
      .c_out (seg_co[g]),
      .c_msb (seg_cm[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
      cy_p  <= '0;
      ovf_p <= 1'b0;
      for (int i = 0; i < NSTG; i++) begin
        sum_p[i] <= '0;
        a_p[i]   <= '0;
        b_p[i]   <= '0;
      end
    end else begin
      // Stage 0 boundary: segment 0 straight from the ports.
      if (rdy[0]) begin
        vld_p[0] <= bus.in_valid;
        sum_p[0] <= WIDTH'(seg_s[0]);
        cy_p[0]  <= seg_co[0];
        a_p[0]   <= bus.a >> SEG;
        b_p[0]   <= b_in >> SEG;
      end
      // Stage i boundary: segment i merged into the carried-forward low sum.
      for (int i = 1; i < NSTG; i++) begin
        if (rdy[i]) begin
          vld_p[i]                 <= vld_p[i-1];
          sum_p[i]                 <= sum_p[i-1];
          sum_p[i][i*SEG +: SEG]   <= seg_s[i];
          cy_p[i]                  <= seg_co[i];
          a_p[i]                   <= a_p[i-1] >> SEG;
          b_p[i]                   <= b_p[i-1] >> SEG;
        end
      end
      if (rdy[NSTG-1]) begin
        ovf_p <= seg_cm[NSTG-1] ^ seg_co[NSTG-1];
      end
    end
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = vld_p[NSTG-1];
  assign bus.s         = sum_p[NSTG-1];
  assign bus.c_out     = cy_p[NSTG-1];
  assign bus.ovf       = ovf_p;

  // Final-stage skew bits and inner-segment MSB carries have no consumer.
  assign unused_skew = ^{a_p[NSTG-1], b_p[NSTG-1], seg_cm};

endmodule
